// File: rtl/rename_map_table.sv
// -----------------------------------------------------------------------------
// rename_map_table
//
// Register-rename map table for the dispatch stage. It sits directly after the
// free list. Each dispatch cycle it does three things:
//   - reads the physical mappings and ready bits of both sources;
//   - replaces the destination mapping with the free-list head (T_new);
//   - hands the displaced mapping (T_old) to the ROB.
// Per-architectural-register ready bits are set from CDB broadcasts. A single
// branch checkpoint of map + ready bits is held and restored on misprediction.
//
// Ports:
//   i_clk               system clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_dispatch_en       instruction presented for rename
//   i_dest_valid        instruction writes a destination
//   i_dest_arch         destination architectural register
//   i_src1_arch/2       source architectural registers
//   i_free_reg          free-list head (T_new)
//   i_free_empty        free list empty
//   i_branch_dispatch   dispatching a branch: take a checkpoint
//   i_branch_correct    outstanding branch resolved correct: release checkpoint
//   i_branch_incorrect  outstanding branch mispredicted: restore checkpoint
//   i_cdb_valid/i_cdb_tag  CDB broadcast
//   o_src1_tag/2, o_src1_ready/2  source mappings and availability
//   o_t_old             previous mapping of the destination (to ROB)
//   o_t_new             equals i_free_reg
//   o_rename_fire       rename accepted (drives free-list pop)
//   o_stall             dispatch requested but refused
//   o_checkpoint_valid  a checkpoint is held
// -----------------------------------------------------------------------------
module rename_map_table #(
    parameter int NUM_GEN_REG  = 32,
    parameter int NUM_PHYS_REG = 64,
    parameter int ZERO_REG     = 31,
    localparam int PR_W        = $clog2(NUM_PHYS_REG),
    localparam int AR_W        = $clog2(NUM_GEN_REG)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_dispatch_en,
    input  logic            i_dest_valid,
    input  logic [AR_W-1:0] i_dest_arch,
    input  logic [AR_W-1:0] i_src1_arch,
    input  logic [AR_W-1:0] i_src2_arch,
    input  logic [PR_W-1:0] i_free_reg,
    input  logic            i_free_empty,
    input  logic            i_branch_dispatch,
    input  logic            i_branch_correct,
    input  logic            i_branch_incorrect,
    input  logic            i_cdb_valid,
    input  logic [PR_W-1:0] i_cdb_tag,
    output logic [PR_W-1:0] o_src1_tag,
    output logic [PR_W-1:0] o_src2_tag,
    output logic            o_src1_ready,
    output logic            o_src2_ready,
    output logic [PR_W-1:0] o_t_old,
    output logic [PR_W-1:0] o_t_new,
    output logic            o_rename_fire,
    output logic            o_stall,
    output logic            o_checkpoint_valid
);

    localparam logic [AR_W-1:0] ZERO_ARCH = AR_W'(ZERO_REG);

    // Live map and its checkpoint copy
    logic [PR_W-1:0]        r_map      [NUM_GEN_REG];
    logic [NUM_GEN_REG-1:0] r_ready;
    logic [PR_W-1:0]        r_cp_map   [NUM_GEN_REG];
    logic [NUM_GEN_REG-1:0] r_cp_ready;
    logic                   r_cp_valid;

    logic [PR_W-1:0]        w_map_next [NUM_GEN_REG];
    logic [NUM_GEN_REG-1:0] w_ready_next;
    logic [NUM_GEN_REG-1:0] w_cp_ready_cdb;

    logic w_need_reg;
    logic w_stall;
    logic w_fire;
    logic w_capture;

    // ------------------------------------------------------------------
    // Dispatch control
    // ------------------------------------------------------------------
    assign w_need_reg = i_dest_valid && (i_dest_arch != ZERO_ARCH);

    // A second branch may only go when the held checkpoint is released in
    // the same cycle. A misprediction suppresses dispatch entirely.
    assign w_stall = i_dispatch_en && !i_branch_incorrect &&
                     ((w_need_reg && i_free_empty) ||
                      (i_branch_dispatch && r_cp_valid && !i_branch_correct));

    assign w_fire    = i_dispatch_en && !i_branch_incorrect && !w_stall && w_need_reg;
    assign w_capture = i_dispatch_en && i_branch_dispatch && !w_stall && !i_branch_incorrect;

    // ------------------------------------------------------------------
    // Per-entry next state
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_GEN_REG; gi++) begin : g_entry
            logic w_live_hit;
            logic w_cp_hit;
            logic w_wr_sel;

            assign w_live_hit = i_cdb_valid && (r_map[gi] == i_cdb_tag);
            assign w_cp_hit   = i_cdb_valid && (r_cp_map[gi] == i_cdb_tag);
            assign w_wr_sel   = w_fire && (i_dest_arch == AR_W'(gi));

            // Checkpoint ready bits also track the CDB so a restore is current
            assign w_cp_ready_cdb[gi] = r_cp_ready[gi] | w_cp_hit;

            // Restore beats rename; the rename's ready=0 beats the CDB
            // (a freshly allocated tag cannot be in flight on the CDB).
            assign w_map_next[gi]   = i_branch_incorrect ? r_cp_map[gi] :
                                      w_wr_sel           ? i_free_reg   :
                                                           r_map[gi];
            assign w_ready_next[gi] = i_branch_incorrect ? w_cp_ready_cdb[gi] :
                                      w_wr_sel           ? 1'b0 :
                                                           (r_ready[gi] | w_live_hit);
        end
    endgenerate

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_GEN_REG; i++) begin
                r_map[i]    <= PR_W'(i);
                r_cp_map[i] <= PR_W'(i);
            end
            r_ready    <= '1;
            r_cp_ready <= '1;
        end else begin
            for (int i = 0; i < NUM_GEN_REG; i++) begin
                r_map[i] <= w_map_next[i];
                // Snapshot reflects the map as it will be after this edge
                if (w_capture) begin
                    r_cp_map[i] <= w_map_next[i];
                end
            end
            r_ready    <= w_ready_next;
            r_cp_ready <= w_capture ? w_ready_next : w_cp_ready_cdb;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cp_valid <= 1'b0;
        end else if (i_branch_incorrect) begin
            r_cp_valid <= 1'b0;
        end else if (w_capture) begin
            r_cp_valid <= 1'b1;
        end else if (i_branch_correct) begin
            r_cp_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_src1_tag   = r_map[i_src1_arch];
    assign o_src2_tag   = r_map[i_src2_arch];
    // Same-cycle CDB bypass so a waking source is seen as ready immediately
    assign o_src1_ready = r_ready[i_src1_arch] ||
                          (i_cdb_valid && (i_cdb_tag == o_src1_tag)) ||
                          (i_src1_arch == ZERO_ARCH);
    assign o_src2_ready = r_ready[i_src2_arch] ||
                          (i_cdb_valid && (i_cdb_tag == o_src2_tag)) ||
                          (i_src2_arch == ZERO_ARCH);

    assign o_t_old            = r_map[i_dest_arch];
    assign o_t_new            = i_free_reg;
    assign o_rename_fire      = w_fire;
    assign o_stall            = w_stall;
    assign o_checkpoint_valid = r_cp_valid;

endmodule

// File: tb/tb_rename_map_table.sv
module tb_rename_map_table;

    logic       clk;
    logic       rst_n;
    logic       de, dv, fe, bd, bc, bi, cv;
    logic [4:0] dest, s1, s2;
    logic [5:0] free, ct;
    logic [5:0] s1_tag, s2_tag, t_old, t_new;
    logic       s1_rdy, s2_rdy, fire, stall, cpv;

    int n_checks = 0;
    int n_fail   = 0;

    rename_map_table dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_dispatch_en      (de),
        .i_dest_valid       (dv),
        .i_dest_arch        (dest),
        .i_src1_arch        (s1),
        .i_src2_arch        (s2),
        .i_free_reg         (free),
        .i_free_empty       (fe),
        .i_branch_dispatch  (bd),
        .i_branch_correct   (bc),
        .i_branch_incorrect (bi),
        .i_cdb_valid        (cv),
        .i_cdb_tag          (ct),
        .o_src1_tag         (s1_tag),
        .o_src2_tag         (s2_tag),
        .o_src1_ready       (s1_rdy),
        .o_src2_ready       (s2_rdy),
        .o_t_old            (t_old),
        .o_t_new            (t_new),
        .o_rename_fire      (fire),
        .o_stall            (stall),
        .o_checkpoint_valid (cpv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        de = 0; dv = 0; dest = 0; s1 = 0; s2 = 0; free = 0;
        fe = 0; bd = 0; bc = 0; bi = 0; cv = 0; ct = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic de, dv; logic [4:0] dest, s1; logic [5:0] free;
        logic fe, bd, bc, bi, cv; logic [5:0] ct;
        logic [5:0] e_s1tag; logic e_s1rdy; logic [5:0] e_told;
        logic e_fire, e_stall, e_cpv;
    } vec_t;

    function automatic vec_t mk(input logic a_de, a_dv, input int a_dest, a_s1, a_free,
                                input logic a_fe, a_bd, a_bc, a_bi, a_cv, input int a_ct,
                                input int e_tag, input logic e_rdy, input int e_told,
                                input logic e_fire, e_stall, e_cpv);
        vec_t v;
        v.de = a_de; v.dv = a_dv; v.dest = 5'(a_dest); v.s1 = 5'(a_s1); v.free = 6'(a_free);
        v.fe = a_fe; v.bd = a_bd; v.bc = a_bc; v.bi = a_bi; v.cv = a_cv; v.ct = 6'(a_ct);
        v.e_s1tag = 6'(e_tag); v.e_s1rdy = e_rdy; v.e_told = 6'(e_told);
        v.e_fire = e_fire; v.e_stall = e_stall; v.e_cpv = e_cpv;
        return v;
    endfunction

    // ---------------- reference model ----------------
    int m_map[32];
    bit m_rdy[32];
    int c_map[32];
    bit c_rdy[32];
    bit m_cpv;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_map[i] = i; m_rdy[i] = 1; c_map[i] = i; c_rdy[i] = 1;
        end
        m_cpv = 0;
    endfunction

    function automatic bit m_need();
        return dv && dest != 31;
    endfunction
    function automatic bit m_stall();
        return de && !bi && ((m_need() && fe) || (bd && m_cpv && !bc));
    endfunction
    function automatic bit m_fire();
        return de && !bi && !m_stall() && m_need();
    endfunction
    function automatic bit m_src_rdy(input int a);
        return m_rdy[a] || (cv && int'(ct) == m_map[a]) || a == 31;
    endfunction

    function automatic void model_step();
        bit f, cap;
        f   = m_fire();
        cap = de && bd && !m_stall() && !bi;
        // checkpoint copy sees the broadcast every edge
        for (int i = 0; i < 32; i++)
            if (cv && c_map[i] == int'(ct)) c_rdy[i] = 1;
        if (bi) begin
            m_map = c_map;
            m_rdy = c_rdy;
            m_cpv = 0;
        end else begin
            for (int i = 0; i < 32; i++)
                if (cv && m_map[i] == int'(ct)) m_rdy[i] = 1;
            if (f) begin
                m_map[dest] = int'(free);
                m_rdy[dest] = 0;
            end
            if (cap) begin
                c_map = m_map;
                c_rdy = m_rdy;
                m_cpv = 1;
            end else if (bc) begin
                m_cpv = 0;
            end
        end
    endfunction

    vec_t tbl[19];

    initial begin
        // de dv dest s1 free fe bd bc bi cv ct | tag rdy told fire stall cpv
        tbl[0]  = mk(0,0, 0, 5, 0,0,0,0,0,0, 0,  5,1, 0,0,0,0);
        tbl[1]  = mk(1,1, 3, 3,32,0,0,0,0,0, 0,  3,1, 3,1,0,0);
        tbl[2]  = mk(0,0, 3, 3, 0,0,0,0,0,0, 0, 32,0,32,0,0,0);
        tbl[3]  = mk(1,1, 5, 5,40,1,0,0,0,0, 0,  5,1, 5,0,1,0);
        tbl[4]  = mk(1,1,31,31,40,1,0,0,0,0, 0, 31,1,31,0,0,0);
        tbl[5]  = mk(1,0, 0, 3, 0,0,1,0,0,0, 0, 32,0, 0,0,0,0);
        tbl[6]  = mk(1,1, 3, 3,33,0,0,0,0,0, 0, 32,0,32,1,0,1);
        tbl[7]  = mk(1,1, 4, 4,34,0,0,0,0,1,32,  4,1, 4,1,0,1);
        tbl[8]  = mk(1,0, 0, 3, 0,0,1,0,0,0, 0, 33,0, 0,0,1,1);
        tbl[9]  = mk(1,1, 7, 7,40,0,0,0,1,0, 0,  7,1, 7,0,0,1);
        tbl[10] = mk(0,0, 4, 3, 0,0,0,0,0,0, 0, 32,1, 4,0,0,0);
        tbl[11] = mk(0,0, 7, 4, 0,0,0,0,0,0, 0,  4,1, 7,0,0,0);
        tbl[12] = mk(1,1, 3, 3,35,0,0,0,0,0, 0, 32,1,32,1,0,0);
        tbl[13] = mk(0,0, 0, 3, 0,0,0,0,0,1,35, 35,1, 0,0,0,0);
        tbl[14] = mk(0,0, 0, 3, 0,0,0,0,0,0, 0, 35,1, 0,0,0,0);
        tbl[15] = mk(1,0, 0, 0, 0,0,1,0,0,0, 0,  0,1, 0,0,0,0);
        tbl[16] = mk(1,0, 0, 0, 0,0,1,1,0,0, 0,  0,1, 0,0,0,1);
        tbl[17] = mk(0,0, 0, 0, 0,0,0,1,0,0, 0,  0,1, 0,0,0,1);
        tbl[18] = mk(0,0, 0, 0, 0,0,0,0,0,0, 0,  0,1, 0,0,0,0);

        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;

        foreach (tbl[k]) begin
            @(negedge clk);
            de = tbl[k].de; dv = tbl[k].dv; dest = tbl[k].dest; s1 = tbl[k].s1;
            s2 = 0; free = tbl[k].free; fe = tbl[k].fe; bd = tbl[k].bd;
            bc = tbl[k].bc; bi = tbl[k].bi; cv = tbl[k].cv; ct = tbl[k].ct;
            #1;
            $display("vec %0d: s1_tag=%0d rdy=%0b t_old=%0d fire=%0b stall=%0b cpv=%0b",
                     k, s1_tag, s1_rdy, t_old, fire, stall, cpv);
            chk($sformatf("vec%0d_s1_tag", k), s1_tag, tbl[k].e_s1tag);
            chk($sformatf("vec%0d_s1_rdy", k), s1_rdy, tbl[k].e_s1rdy);
            chk($sformatf("vec%0d_t_old", k),  t_old,  tbl[k].e_told);
            chk($sformatf("vec%0d_t_new", k),  t_new,  tbl[k].free);
            chk($sformatf("vec%0d_fire", k),   fire,   tbl[k].e_fire);
            chk($sformatf("vec%0d_stall", k),  stall,  tbl[k].e_stall);
            chk($sformatf("vec%0d_cpv", k),    cpv,    tbl[k].e_cpv);
        end

        // ---------- asynchronous reset mid-operation ----------
        @(negedge clk);
        idle_inputs(); de = 1; bd = 1; s1 = 3;
        @(negedge clk);
        idle_inputs(); s1 = 3;
        #1;
        chk("arst_pre_cpv", cpv, 1);
        chk("arst_pre_tag", s1_tag, 35);
        #1 rst_n = 0;
        #1;
        $display("async reset: s1_tag=%0d rdy=%0b cpv=%0b", s1_tag, s1_rdy, cpv);
        chk("arst_tag", s1_tag, 3);
        chk("arst_rdy", s1_rdy, 1);
        chk("arst_cpv", cpv, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();

        // ---------- randomized phase against the model ----------
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            de   = ($urandom_range(0, 9) < 7);
            dv   = ($urandom_range(0, 9) < 7);
            dest = 5'($urandom_range(0, 31));
            s1   = 5'($urandom_range(0, 31));
            s2   = 5'($urandom_range(0, 31));
            free = 6'($urandom_range(0, 63));
            fe   = ($urandom_range(0, 9) == 0);
            bd   = ($urandom_range(0, 6) == 0);
            bc   = ($urandom_range(0, 9) == 0);
            bi   = ($urandom_range(0, 19) == 0);
            cv   = $urandom_range(0, 1);
            ct   = $urandom_range(0, 1) ? 6'(m_map[$urandom_range(0, 31)])
                                        : 6'($urandom_range(0, 63));
            #1;
            $display("rnd %0d: de=%0b dv=%0b d=%0d bd=%0b bc=%0b bi=%0b fire=%0b stall=%0b cpv=%0b",
                     c, de, dv, dest, bd, bc, bi, fire, stall, cpv);
            chk("rnd_s1_tag", s1_tag, m_map[s1]);
            chk("rnd_s2_tag", s2_tag, m_map[s2]);
            chk("rnd_s1_rdy", s1_rdy, m_src_rdy(s1));
            chk("rnd_s2_rdy", s2_rdy, m_src_rdy(s2));
            chk("rnd_t_old",  t_old,  m_map[dest]);
            chk("rnd_t_new",  t_new,  free);
            chk("rnd_fire",   fire,   m_fire());
            chk("rnd_stall",  stall,  m_stall());
            chk("rnd_cpv",    cpv,    m_cpv);
            model_step();
        end

        // final full-table sweep
        @(negedge clk);
        idle_inputs();
        for (int a = 0; a < 32; a++) begin
            s1 = 5'(a);
            #1;
            chk("sweep_tag", s1_tag, m_map[a]);
            chk("sweep_rdy", s1_rdy, m_src_rdy(a));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
- Register-rename map table that sits directly downstream of the free list in dispatch.
- Each dispatch cycle it:
  - reads source mappings and ready bits;
  - replaces the destination mapping with the free list's head register (T_new);
  - returns the displaced mapping (T_old) to the ROB.
- Tracks per-architectural-register ready bits from CDB broadcasts.
- Holds one branch checkpoint, restored on misprediction.

Parameters:
NUM_GEN_REG, 32, architectural registers
NUM_PHYS_REG, 64, physical registers; PR_W = clog2(NUM_PHYS_REG), AR_W = clog2(NUM_GEN_REG)
ZERO_REG, 31, architectural zero register; never renamed, always ready

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
dispatch_en  in  1  instruction presented for rename this cycle
dest_valid  in  1  instruction writes a destination register
dest_arch  in  AR_W  destination architectural register
src1_arch  in  AR_W  source 1 architectural register
src2_arch  in  AR_W  source 2 architectural register
free_reg  in  PR_W  head of free list (T_new)
free_empty  in  1  free list empty
branch_dispatch  in  1  dispatching instruction is a branch; take checkpoint
branch_correct  in  1  outstanding branch resolved correct; release checkpoint
branch_incorrect  in  1  outstanding branch mispredicted; restore checkpoint
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  PR_W  CDB physical tag
src1_tag, src2_tag  out  PR_W each  current physical mapping of sources
src1_ready, src2_ready  out  1 each  source value available
T_old  out  PR_W  previous mapping of dest_arch (to ROB)
T_new  out  PR_W  equals free_reg (to ROB/RS)
rename_fire  out  1  rename accepted; drives free-list dispatch_en
stall  out  1  dispatch_en asserted but rename refused
checkpoint_valid  out  1  a checkpoint is held

Behaviour:
- Reset (reset==0, asynchronous):
  - map[i]=i, ready[i]=1 for all i;
  - checkpoint map/ready cleared to the same values;
  - checkpoint_valid=0.
- All outputs follow combinationally from state after reset: rename_fire=0, stall=0.
- need_reg = dest_valid && dest_arch!=ZERO_REG.
- stall = dispatch_en && !branch_incorrect && ((need_reg && free_empty) || (branch_dispatch && checkpoint_valid && !branch_correct)).
- rename_fire = dispatch_en && !branch_incorrect && !stall && need_reg.
- Sources (combinational):
  - srcN_tag = map[srcN_arch] before this cycle's update.
  - srcN_ready = ready[srcN_arch] || (cdb_valid && cdb_tag==srcN_tag) || srcN_arch==ZERO_REG.
  - An instruction never depends on its own destination.
- T_old = map[dest_arch], combinational; meaningful only when rename_fire.
- On a rename_fire edge: map[dest_arch] <= free_reg, ready[dest_arch] <= 0.
- CDB, per edge, live table: for every i with map[i]==cdb_tag, ready[i] <= 1.
  - Applies to entries not being overwritten this cycle.
  - A same-cycle rename writes ready=0 for its dest; the new tag cannot match the CDB.
- CDB, per edge, checkpoint copy: the same ready update applies, so restored ready bits are current.
- Checkpoint capture: dispatch_en && branch_dispatch && !stall && !branch_incorrect.
  - Snapshot map/ready as they are after the edge.
  - Branches carry no destination, so the snapshot equals the current map plus the CDB update.
  - Sets checkpoint_valid.
- Single-depth checkpoint. A second branch while one is outstanding stalls.
  - Exception: if branch_correct arrives the same cycle, the old checkpoint is released and the new one captured.
- branch_correct: checkpoint_valid <= 0 (unless a new capture occurs the same edge).
- branch_incorrect has highest priority:
  - map <= checkpoint map; ready <= checkpoint ready with the same-cycle CDB applied;
  - checkpoint_valid <= 0;
  - dispatch ignored (rename_fire=0, stall=0).
- branch_incorrect with checkpoint_valid==0 is a protocol error. The map is still loaded from the checkpoint copy.
- ZERO_REG mapping never changes; its ready bit stays 1.
- Reset asserted mid-operation discards the checkpoint and all pending state immediately.

Test Plan:
- Reset release -> src1_arch=5 gives src1_tag=5, src1_ready=1; checkpoint_valid=0.
- Dispatch dest_arch=3, free_reg=32 -> T_old=3, rename_fire=1.
  - Next cycle src1_arch=3 gives tag 32, ready=0.
  - Then cdb_tag=32 -> ready=1 next cycle; same-cycle bypass gives src1_ready=1 during the broadcast.
- dest_valid=1, free_empty=1 -> stall=1, rename_fire=0, map unchanged. dest_arch=31 with free_empty=1 -> no stall, no rename.
- Branch checkpoint, then rename r3->33 and r4->34, then branch_incorrect -> r3 maps 32, r4 maps 4; checkpoint_valid=0.
  - If cdb_tag=32 was broadcast between checkpoint and restore, r3 is restored ready=1.
- Second branch_dispatch while checkpoint held -> stall=1. Same with branch_correct in the same cycle -> no stall, checkpoint_valid stays 1 with the new snapshot.
- branch_incorrect concurrent with dispatch of dest r7 and free_reg=40 -> rename_fire=0, r7 maps to its checkpointed tag.
  - Assert reset low asynchronously mid-sequence -> identity map immediately.
